// File: rtl/sobel_edge.sv
// sobel_edge: three-stage 3x3 Sobel gradient magnitude with raster border/eol/eof tracking.
// Optional build macro: SOBEL_BINARY_EN (binarise output against the threshold port).
module sobel_edge #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      win_valid,
    input  logic [9*DATA_WIDTH-1:0]   win_data,
    output logic                      win_ready,
    input  logic [DATA_WIDTH-1:0]     threshold,
    output logic                      pix_valid,
    output logic [DATA_WIDTH-1:0]     pix_out,
    output logic                      pix_eol,
    output logic                      pix_eof,
    input  logic                      pix_ready
);

    localparam int unsigned GW = DATA_WIDTH + 3;
    localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

    logic [DATA_WIDTH-1:0] w [9];
    logic                  en;
    logic                  acc;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic                  col_last;
    logic                  row_last;

    logic [GW-1:0]         pos_x, neg_x, pos_y, neg_y;
    logic signed [GW-1:0]  gx_c, gy_c;
    logic [GW-1:0]         abs_x, abs_y, mag_c;
    logic [DATA_WIDTH-1:0] sat_c, pix_next;

    logic                  s1_v, s1_border, s1_eol, s1_eof;
    logic signed [GW-1:0]  s1_gx, s1_gy;
    logic                  s2_v, s2_border, s2_eol, s2_eof;
    logic [GW-1:0]         s2_mag;

    // Unpack the flattened window into raster-ordered pixels
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w[k] = win_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Global stall: everything freezes while an output pixel is refused
    assign en        = !(pix_valid && !pix_ready);
    assign win_ready = en;
    assign acc       = win_valid && en;
    assign col_last  = (col == COL_LAST);
    assign row_last  = (row == ROW_LAST);

    // Raster position of the next accepted window centre
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Horizontal and vertical Sobel kernels, operands zero-extended to GW bits
    always_comb begin
        pos_x = GW'(w[2]) + (GW'(w[5]) << 1) + GW'(w[8]);
        neg_x = GW'(w[0]) + (GW'(w[3]) << 1) + GW'(w[6]);
        pos_y = GW'(w[6]) + (GW'(w[7]) << 1) + GW'(w[8]);
        neg_y = GW'(w[0]) + (GW'(w[1]) << 1) + GW'(w[2]);
        gx_c  = signed'(pos_x - neg_x);
        gy_c  = signed'(pos_y - neg_y);
    end

    // Stage 1: gradients plus position flags captured at accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v      <= 1'b0;
            s1_gx     <= '0;
            s1_gy     <= '0;
            s1_border <= 1'b0;
            s1_eol    <= 1'b0;
            s1_eof    <= 1'b0;
        end else if (en) begin
            s1_v      <= acc;
            s1_gx     <= gx_c;
            s1_gy     <= gy_c;
            s1_border <= acc && (col == '0 || col_last || row == '0 || row_last);
            s1_eol    <= acc && col_last;
            s1_eof    <= acc && col_last && row_last;
        end
    end

    // |gx| + |gy|; the largest possible sum still fits in GW unsigned bits
    always_comb begin
        abs_x = s1_gx[GW-1] ? unsigned'(-s1_gx) : unsigned'(s1_gx);
        abs_y = s1_gy[GW-1] ? unsigned'(-s1_gy) : unsigned'(s1_gy);
        mag_c = abs_x + abs_y;
    end

    // Stage 2: magnitude
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_v      <= 1'b0;
            s2_mag    <= '0;
            s2_border <= 1'b0;
            s2_eol    <= 1'b0;
            s2_eof    <= 1'b0;
        end else if (en) begin
            s2_v      <= s1_v;
            s2_mag    <= mag_c;
            s2_border <= s1_border;
            s2_eol    <= s1_eol;
            s2_eof    <= s1_eof;
        end
    end

    // Saturate, optionally binarise, and blank the frame border
    always_comb begin
        sat_c = (s2_mag > GW'(PIX_MAX)) ? PIX_MAX : s2_mag[DATA_WIDTH-1:0];
`ifdef SOBEL_BINARY_EN
        pix_next = (sat_c >= threshold) ? PIX_MAX : '0;
`else
        pix_next = sat_c;
`endif
        if (s2_border) begin
            pix_next = '0;
        end
    end

`ifndef SOBEL_BINARY_EN
    logic unused_threshold;
    assign unused_threshold = ^threshold;
`endif

    // Stage 3: registered output pixel and side-band flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid <= 1'b0;
            pix_out   <= '0;
            pix_eol   <= 1'b0;
            pix_eof   <= 1'b0;
        end else if (en) begin
            pix_valid <= s2_v;
            pix_out   <= pix_next;
            pix_eol   <= s2_eol;
            pix_eof   <= s2_eof;
        end
    end

endmodule
